mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter AW, 10, word-address width (1024-word unified memory).
REQ-002 Parameter DW, 32, data width.
REQ-003 Parameter RD_LAT, 2, memory read latency in cycles (legal 1..4).
REQ-004 Parameter STARVE_MAX, 4, consecutive lost IF requests before IF is forced to win.
REQ-005 clk1 input 1: single clock, all logic on posedge; reset is synchronous and active-high.
REQ-006 reset input 1: synchronous, active-high.
REQ-007 halt input 1: high blocks new IF grants; data port still served.
REQ-008 if_req input 1 / if_addr input AW: instruction-fetch read request and address.
REQ-009 if_gnt output 1 / if_rvalid output 1 / if_rdata output DW: IF grant pulse, read-data valid pulse, read data.
REQ-010 dm_req input 1 / dm_we input 1 / dm_addr input AW / dm_wdata input DW: load/store request.
REQ-011 dm_gnt output 1 / dm_rvalid output 1 / dm_rdata output DW: data grant pulse, load-data valid pulse, load data.
REQ-012 mem_en output 1 / mem_we output 1 / mem_addr output AW / mem_wdata output DW: single memory port.
REQ-013 mem_rdata input DW: valid exactly RD_LAT cycles after the mem_en && !mem_we cycle.

Function
REQ-014 FSM states IDLE, WAIT; grants are issued only in IDLE.
REQ-015 IDLE: at most one grant per cycle; gnt, mem_en, mem_addr, mem_we, mem_wdata driven combinationally in the grant cycle.
REQ-016 Requester holds req and payload stable until its gnt; gnt is a one-cycle pulse; req may drop only after gnt.
REQ-017 Base priority: dm_req wins over if_req (older instruction first).
REQ-018 Read grant (IF, or DM with dm_we=0) moves IDLE->WAIT; WAIT lasts RD_LAT cycles; owner tag latched at grant.
REQ-019 On the final WAIT cycle, mem_rdata is routed to the owner's rdata, its rvalid pulses for one cycle, and the FSM returns to IDLE; a new grant is allowed in the following cycle.
REQ-020 Write grant (dm_we=1) completes in the grant cycle: no rvalid, FSM stays in IDLE.
REQ-021 halt=1: if_gnt forced 0; an IF read already in WAIT still completes with if_rvalid.
REQ-022 if_rdata/dm_rdata hold their last delivered value between rvalid pulses.
REQ-023 Starvation counter (3 bits, saturating): increments each IDLE cycle in which if_req=1, halt=0 and DM wins; clears on if_gnt; does not count in WAIT.
REQ-024 When counter == STARVE_MAX and if_req=1, halt=0: IF wins over dm_req that cycle.
REQ-025 if_req and dm_req never both granted; mem_en never asserted in WAIT.

Reset
REQ-026 reset=1 at a clock edge: state IDLE, counter 0, owner cleared, all gnt/rvalid/mem_en/mem_we 0, rdata outputs 0.
REQ-027 Reset during WAIT discards the outstanding read: no rvalid is issued for it after reset.
REQ-028 Outputs are 0 during every cycle in which reset is high.

Configuration
REQ-029 Macro ARB_STARVE_GUARD_EN defined: REQ-023/024 are active.
REQ-030 Macro undefined: no counter is built; strict data priority; IF may starve indefinitely.

Structure
REQ-031 Shared package mips32_pkg holds the owner enum (OWN_IF, OWN_DM), the FSM state enum, and default AW/DW.
REQ-032 One sub-module, arb_rd_tracker: WAIT-cycle countdown, owner tag and rvalid/rdata steering.

Verification
REQ-033 IF-only: if_req, if_addr=5, mem word 5=0xDEADBEEF -> if_gnt at cycle 0, if_rvalid with 0xDEADBEEF at cycle RD_LAT, no further grant until cycle RD_LAT+1.
REQ-034 Collision: if_req and dm_req(read, addr 8) in the same cycle -> dm_gnt first, dm_rvalid after RD_LAT cycles, then if_gnt.
REQ-035 Store: dm_we=1, addr 3, data 0x12 -> mem_we=1 in the grant cycle, no dm_rvalid; next-cycle IF request is granted immediately.
REQ-036 Starvation (macro defined, STARVE_MAX=4): dm writes every cycle with if_req held -> if_gnt on the 5th IDLE cycle, counter then 0; macro undefined -> no if_gnt.
REQ-037 halt=1 during an outstanding IF read -> if_rvalid still delivered; subsequent if_req not granted while halt=1.
REQ-038 reset asserted in WAIT -> no rvalid, state IDLE, and the first post-reset request is granted on the first cycle after reset deasserts.

Source files
------------

// File: rtl/mips32_pkg.sv
// Shared types for the unified-memory port arbiter: requester owner tag,
// arbiter FSM state and default address/data widths.
package mips32_pkg;

    localparam int DEF_AW = 10;
    localparam int DEF_DW = 32;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF requester, DM requester and single memory port signals.
// slave = the arbiter, master = requesters plus memory.
interface mem_port_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic          halt;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_gnt;
    logic          dm_rvalid;
    logic [DW-1:0] dm_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  halt, if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output halt, if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/arb_rd_tracker.sv
// Read tracker: IDLE/WAIT FSM, RD_LAT-cycle countdown, owner tag and
// steering of mem_rdata onto the owning requester's rvalid/rdata.
module arb_rd_tracker
    import mips32_pkg::*;
#(
    parameter int DW     = DEF_DW,
    parameter int RD_LAT = 2
) (
    input  logic          clk1,
    input  logic          reset,
    input  logic          rd_start,
    input  owner_e        rd_owner,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata
);

    arb_state_e    state_r;
    logic [2:0]    cnt_r;
    owner_e        owner_r;
    logic [DW-1:0] if_hold_r;
    logic [DW-1:0] dm_hold_r;
    logic          last_s;

    assign last_s = (state_r == ST_WAIT) && (cnt_r == 3'd1);
    assign busy   = (state_r == ST_WAIT);

    // FSM: capture owner on a read grant, count down WAIT, latch delivered data
    always_ff @(posedge clk1) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 3'd0;
            owner_r   <= OWN_IF;
            if_hold_r <= '0;
            dm_hold_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (rd_start) begin
                        state_r <= ST_WAIT;
                        cnt_r   <= 3'(RD_LAT);
                        owner_r <= rd_owner;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == 3'd1) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= 3'd0;
                        if (owner_r == OWN_IF) begin
                            if_hold_r <= mem_rdata;
                        end else begin
                            dm_hold_r <= mem_rdata;
                        end
                    end else begin
                        cnt_r <= cnt_r - 3'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 3'd0;
                end
            endcase
        end
    end

    // Data is live on the final WAIT cycle, otherwise the last delivered word
    always_comb begin
        if_rvalid = 1'b0;
        dm_rvalid = 1'b0;
        if_rdata  = if_hold_r;
        dm_rdata  = dm_hold_r;
        if (reset) begin
            if_rdata = '0;
            dm_rdata = '0;
        end else if (last_s) begin
            if (owner_r == OWN_IF) begin
                if_rvalid = 1'b1;
                if_rdata  = mem_rdata;
            end else begin
                dm_rvalid = 1'b1;
                dm_rdata  = mem_rdata;
            end
        end else begin
            if_rvalid = 1'b0;
            dm_rvalid = 1'b0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (IF, DM) arbiter for a single-port unified memory.
// Optional IF starvation guard built when ARB_STARVE_GUARD_EN is defined.
module mem_port_arbiter
    import mips32_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int RD_LAT     = 2,
    parameter int STARVE_MAX = 4
) (
    input logic               clk1,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);

    logic          busy_s;
    logic          if_ok_s;
    logic          starve_win_s;
    logic          if_gnt_s;
    logic          dm_gnt_s;
    logic          rd_start_s;
    owner_e        rd_owner_s;
    logic          mem_we_s;
    logic [AW-1:0] mem_addr_s;
    logic [DW-1:0] mem_wdata_s;

    assign if_ok_s = bus.if_req && !bus.halt;

`ifdef ARB_STARVE_GUARD_EN
    logic [2:0] starve_cnt_r;

    assign starve_win_s = if_ok_s && (starve_cnt_r == 3'(STARVE_MAX));

    // Count IDLE cycles where an eligible IF request loses to DM; saturate at 7
    always_ff @(posedge clk1) begin
        if (reset) begin
            starve_cnt_r <= 3'd0;
        end else if (if_gnt_s) begin
            starve_cnt_r <= 3'd0;
        end else if (!busy_s && if_ok_s && dm_gnt_s && (starve_cnt_r != 3'd7)) begin
            starve_cnt_r <= starve_cnt_r + 3'd1;
        end
    end
`else
    // Strict data priority; the limit only exists for negative (illegal) settings.
    assign starve_win_s = (STARVE_MAX < 0) ? if_ok_s : 1'b0;
`endif

    // Grant selection: IDLE only, DM first unless IF has hit the starvation limit
    always_comb begin
        if_gnt_s = 1'b0;
        dm_gnt_s = 1'b0;
        if (!reset && !busy_s) begin
            if (starve_win_s) begin
                if_gnt_s = 1'b1;
            end else if (bus.dm_req) begin
                dm_gnt_s = 1'b1;
            end else if (if_ok_s) begin
                if_gnt_s = 1'b1;
            end else begin
                dm_gnt_s = 1'b0;
            end
        end else begin
            if_gnt_s = 1'b0;
            dm_gnt_s = 1'b0;
        end
    end

    // Memory port mux driven by whichever requester holds the grant
    always_comb begin
        mem_we_s    = dm_gnt_s && bus.dm_we;
        mem_addr_s  = '0;
        mem_wdata_s = '0;
        if (dm_gnt_s) begin
            mem_addr_s = bus.dm_addr;
        end else if (if_gnt_s) begin
            mem_addr_s = bus.if_addr;
        end else begin
            mem_addr_s = '0;
        end
        if (mem_we_s) begin
            mem_wdata_s = bus.dm_wdata;
        end else begin
            mem_wdata_s = '0;
        end
    end

    assign rd_start_s = if_gnt_s || (dm_gnt_s && !bus.dm_we);
    assign rd_owner_s = if_gnt_s ? OWN_IF : OWN_DM;

    assign bus.if_gnt    = if_gnt_s;
    assign bus.dm_gnt    = dm_gnt_s;
    assign bus.mem_en    = if_gnt_s || dm_gnt_s;
    assign bus.mem_we    = mem_we_s;
    assign bus.mem_addr  = mem_addr_s;
    assign bus.mem_wdata = mem_wdata_s;

    arb_rd_tracker #(
        .DW     (DW),
        .RD_LAT (RD_LAT)
    ) u_rd_tracker (
        .clk1      (clk1),
        .reset     (reset),
        .rd_start  (rd_start_s),
        .rd_owner  (rd_owner_s),
        .mem_rdata (bus.mem_rdata),
        .busy      (busy_s),
        .if_rvalid (bus.if_rvalid),
        .if_rdata  (bus.if_rdata),
        .dm_rvalid (bus.dm_rvalid),
        .dm_rdata  (bus.dm_rdata)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural RD_LAT-cycle memory.
// Starvation expectations follow ARB_STARVE_GUARD_EN.
module tb_mem_port_arbiter;

    localparam int AW         = 10;
    localparam int DW         = 32;
    localparam int RD_LAT     = 2;
    localparam int STARVE_MAX = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk1  = 1'b0;
    logic reset = 1'b1;
    int   tests_run    = 0;
    int   tests_failed = 0;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(
        .AW         (AW),
        .DW         (DW),
        .RD_LAT     (RD_LAT),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk1  (clk1),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk1 = ~clk1;

    // Memory model: preload under reset, write on mem_we, read data RD_LAT cycles later
    logic [DW-1:0] mem [0:1023];
    logic [AW-1:0] pipe_addr [RD_LAT];
    logic          pipe_vld  [RD_LAT];

    always @(posedge clk1) begin
        if (reset) begin
            mem[3] <= 32'h0000_0000;
            mem[5] <= 32'hDEAD_BEEF;
            mem[6] <= 32'h0000_0066;
            mem[8] <= 32'hCAFE_0008;
        end else if (bus.mem_en && bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    always @(posedge clk1) begin
        pipe_vld[0]  <= bus.mem_en && !bus.mem_we;
        pipe_addr[0] <= bus.mem_addr;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld[i]  <= pipe_vld[i-1];
            pipe_addr[i] <= pipe_addr[i-1];
        end
    end

    assign bus.mem_rdata = pipe_vld[RD_LAT-1] ? mem[pipe_addr[RD_LAT-1]] : 32'h0000_0000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic go();
        @(posedge clk1);
        #1;
    endtask

    task automatic mid();
        @(negedge clk1);
    endtask

    initial begin
        bus.halt     = 1'b0;
        bus.if_req   = 1'b1;
        bus.if_addr  = 10'd5;
        bus.dm_req   = 1'b0;
        bus.dm_we    = 1'b0;
        bus.dm_addr  = 10'd0;
        bus.dm_wdata = 32'h0;

        // Outputs held at zero while reset is high, even with a pending request
        go(); go(); mid();
        check("rst_if_gnt",   {31'd0, bus.if_gnt}, 32'd0);
        check("rst_mem_en",   {31'd0, bus.mem_en}, 32'd0);
        check("rst_if_rdata", bus.if_rdata, 32'd0);
        check("rst_dm_rdata", bus.dm_rdata, 32'd0);

        // IF-only read of word 5, then a back-to-back IF request for word 6
        go(); reset = 1'b0;
        mid();
        check("if_gnt",      {31'd0, bus.if_gnt}, 32'd1);
        check("if_mem_addr", {22'd0, bus.mem_addr}, 32'd5);
        check("if_mem_we",   {31'd0, bus.mem_we}, 32'd0);
        for (int k = 1; k <= RD_LAT; k++) begin
            go();
            bus.if_addr = 10'd6;
            mid();
            check("if_wait_gnt",    {31'd0, bus.if_gnt}, 32'd0);
            check("if_wait_mem_en", {31'd0, bus.mem_en}, 32'd0);
            check("if_rvalid",      {31'd0, bus.if_rvalid}, (k == RD_LAT) ? 32'd1 : 32'd0);
        end
        check("if_rdata", bus.if_rdata, 32'hDEAD_BEEF);
        go(); mid();
        check("if_next_gnt",   {31'd0, bus.if_gnt}, 32'd1);
        check("if_next_addr",  {22'd0, bus.mem_addr}, 32'd6);
        check("if_rdata_hold", bus.if_rdata, 32'hDEAD_BEEF);
        go(); bus.if_req = 1'b0;
        repeat (RD_LAT - 1) go();
        mid();
        check("if2_rvalid", {31'd0, bus.if_rvalid}, 32'd1);
        check("if2_rdata",  bus.if_rdata, 32'h0000_0066);

        // Collision: DM read of word 8 beats IF, IF granted right after the DM read
        go();
        bus.if_req = 1'b1; bus.if_addr = 10'd5;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 10'd8;
        mid();
        check("col_dm_gnt",   {31'd0, bus.dm_gnt}, 32'd1);
        check("col_if_gnt",   {31'd0, bus.if_gnt}, 32'd0);
        check("col_mem_addr", {22'd0, bus.mem_addr}, 32'd8);
        go(); bus.dm_req = 1'b0;
        repeat (RD_LAT - 1) go();
        mid();
        check("col_dm_rvalid", {31'd0, bus.dm_rvalid}, 32'd1);
        check("col_dm_rdata",  bus.dm_rdata, 32'hCAFE_0008);
        check("col_if_rvalid", {31'd0, bus.if_rvalid}, 32'd0);
        check("col_if_wait",   {31'd0, bus.if_gnt}, 32'd0);
        go(); mid();
        check("col_if_gnt2", {31'd0, bus.if_gnt}, 32'd1);
        go(); bus.if_req = 1'b0;
        repeat (RD_LAT - 1) go();
        mid();
        check("col_if_rdata", bus.if_rdata, 32'hDEAD_BEEF);

        // Store 0x12 to word 3, IF granted the very next cycle and reads it back
        go();
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 10'd3; bus.dm_wdata = 32'h12;
        mid();
        check("st_dm_gnt",    {31'd0, bus.dm_gnt}, 32'd1);
        check("st_mem_we",    {31'd0, bus.mem_we}, 32'd1);
        check("st_mem_addr",  {22'd0, bus.mem_addr}, 32'd3);
        check("st_mem_wdata", bus.mem_wdata, 32'h12);
        go();
        bus.dm_req = 1'b0; bus.dm_we = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 10'd3;
        mid();
        check("st_no_rvalid", {31'd0, bus.dm_rvalid}, 32'd0);
        check("st_if_gnt",    {31'd0, bus.if_gnt}, 32'd1);
        go(); bus.if_req = 1'b0;
        repeat (RD_LAT - 1) go();
        mid();
        check("st_if_rvalid", {31'd0, bus.if_rvalid}, 32'd1);
        check("st_if_rdata",  bus.if_rdata, 32'h12);

        // Halt: outstanding IF read completes, new IF requests wait for halt release
        go(); bus.if_req = 1'b1; bus.if_addr = 10'd5;
        mid();
        check("halt_if_gnt", {31'd0, bus.if_gnt}, 32'd1);
        go(); bus.if_req = 1'b0; bus.halt = 1'b1;
        repeat (RD_LAT - 1) go();
        mid();
        check("halt_rvalid", {31'd0, bus.if_rvalid}, 32'd1);
        check("halt_rdata",  bus.if_rdata, 32'hDEAD_BEEF);
        go(); bus.if_req = 1'b1; bus.if_addr = 10'd6;
        mid();
        check("halt_block1", {31'd0, bus.if_gnt}, 32'd0);
        go(); mid();
        check("halt_block2", {31'd0, bus.if_gnt}, 32'd0);
        check("halt_mem_en", {31'd0, bus.mem_en}, 32'd0);
        go(); bus.halt = 1'b0;
        mid();
        check("halt_release_gnt", {31'd0, bus.if_gnt}, 32'd1);
        go(); bus.if_req = 1'b0;
        repeat (RD_LAT - 1) go();
        mid();
        check("halt_release_rdata", bus.if_rdata, 32'h0000_0066);

        // Reset during WAIT drops the read; first request after reset is granted at once
        go(); bus.if_req = 1'b1; bus.if_addr = 10'd5;
        mid();
        check("rw_if_gnt", {31'd0, bus.if_gnt}, 32'd1);
        go(); bus.if_req = 1'b0; reset = 1'b1;
        mid();
        check("rw_rst_rvalid", {31'd0, bus.if_rvalid}, 32'd0);
        check("rw_rst_rdata",  bus.if_rdata, 32'd0);
        go();
        reset = 1'b0;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 10'd8;
        mid();
        check("rw_post_gnt",    {31'd0, bus.dm_gnt}, 32'd1);
        check("rw_post_rvalid", {31'd0, bus.if_rvalid}, 32'd0);
        go(); bus.dm_req = 1'b0;
        repeat (RD_LAT - 1) go();
        mid();
        check("rw_dm_rvalid",  {31'd0, bus.dm_rvalid}, 32'd1);
        check("rw_dm_rdata",   bus.dm_rdata, 32'hCAFE_0008);
        check("rw_if_silent",  {31'd0, bus.if_rvalid}, 32'd0);

        // Starvation: DM writes every cycle with IF held
        go();
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 10'd9; bus.dm_wdata = 32'hA5;
        bus.if_req = 1'b1; bus.if_addr = 10'd5;
        for (int c = 1; c <= 10 + RD_LAT; c++) begin
            logic exp_if;
            logic in_wait;
            logic exp_dm;
            exp_if  = GUARD && ((c == STARVE_MAX + 1) || (c == 2 * STARVE_MAX + 2 + RD_LAT));
            in_wait = GUARD && (c > STARVE_MAX + 1) && (c <= STARVE_MAX + 1 + RD_LAT);
            exp_dm  = !exp_if && !in_wait;
            mid();
            check($sformatf("starve_if_gnt_c%0d", c), {31'd0, bus.if_gnt}, {31'd0, exp_if});
            check($sformatf("starve_dm_gnt_c%0d", c), {31'd0, bus.dm_gnt}, {31'd0, exp_dm});
            check($sformatf("starve_if_rvalid_c%0d", c), {31'd0, bus.if_rvalid},
                  {31'd0, GUARD && (c == STARVE_MAX + 1 + RD_LAT)});
            go();
        end
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.if_req = 1'b0;
        repeat (RD_LAT + 1) go();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
